cia_int_ctrl: RTL and testbench

// Register-select decoder and interrupt controller for one CIA. Decodes rs into
// per-register read/write strobes for timer A, timer B, TOD and SDR, muxes their

---
 rtl/cia_int_ctrl.sv | 105 ++++++++++
 tb/tb_cia_int_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cia_int_ctrl.sv
// CIA register-select decoder and interrupt controller: per-register strobes,
// read-data mux, ICR event latch / mask / read-clear and the registered irq_n.
module cia_int_ctrl #(
  parameter int FLAG_SYNC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       cs,
  input  logic       wr,
  input  logic [3:0] rs,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [7:0] ta_do,
  input  logic [7:0] tb_do,
  input  logic [7:0] tod_do,
  input  logic [7:0] sdr_do,
  output logic       ta_lo,
  output logic       ta_hi,
  output logic       ta_cr,
  output logic       tb_lo,
  output logic       tb_hi,
  output logic       tb_cr,
  output logic       tod_sel,
  output logic       sdr_sel,
  input  logic       ta_irq,
  input  logic       tb_irq,
  input  logic       alrm,
  input  logic       ser,
  input  logic       flag_n,
  output logic       irq_n
);

  localparam logic [3:0] RS_ICR = 4'hD;

  logic [4:0]           icr, mask, icr_next, mask_next, evt;
  logic [FLAG_SYNC-1:0] flag_sync;
  logic                 flag_prev, flag_evt, ir, icr_rd, icr_wr;
  logic                 unused_data_in;

  assign unused_data_in = ^data_in[6:5];

  // Strobes
  assign ta_lo   = cs & (rs == 4'h4);
  assign ta_hi   = cs & (rs == 4'h5);
  assign ta_cr   = cs & (rs == 4'hE);
  assign tb_lo   = cs & (rs == 4'h6);
  assign tb_hi   = cs & (rs == 4'h7);
  assign tb_cr   = cs & (rs == 4'hF);
  assign tod_sel = cs & (rs[3:2] == 2'b10);
  assign sdr_sel = cs & (rs == 4'hC);

  assign ir = |(icr & mask);

  always_comb begin
    data_out = '0;
    if (cs && !wr) begin
      case (rs)
        4'h4, 4'h5, 4'hE:       data_out = ta_do;
        4'h6, 4'h7, 4'hF:       data_out = tb_do;
        4'h8, 4'h9, 4'hA, 4'hB: data_out = tod_do;
        4'hC:                   data_out = sdr_do;
        RS_ICR:                 data_out = {ir, 2'b00, icr};
        default:                data_out = '0;
      endcase
    end
  end

  // Synchroniser runs ungated so the pin is always tracked; it resets high so
  // reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flag_sync <= '1;
    else          flag_sync <= {flag_sync[FLAG_SYNC-2:0], flag_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     flag_prev <= 1'b1;
    else if (clk7_en) flag_prev <= flag_sync[FLAG_SYNC-1];
  end

  assign flag_evt = flag_prev & ~flag_sync[FLAG_SYNC-1];
  assign evt      = {flag_evt, ser, alrm, tb_irq, ta_irq};
  assign icr_rd   = cs & ~wr & (rs == RS_ICR);
  assign icr_wr   = cs &  wr & (rs == RS_ICR);

  // Events OR in after the clear so a pulse coincident with the read survives.
  always_comb begin
    icr_next  = (icr_rd ? 5'd0 : icr) | evt;
    mask_next = mask;
    if (icr_wr) mask_next = data_in[7] ? (mask | data_in[4:0]) : (mask & ~data_in[4:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icr   <= '0;
      mask  <= '0;
      irq_n <= 1'b1;
    end else if (clk7_en) begin
      icr   <= icr_next;
      mask  <= mask_next;
      irq_n <= ~|(icr_next & mask_next);
    end
  end

endmodule

// File: tb/tb_cia_int_ctrl.sv
// Self-checking bench for cia_int_ctrl: directed ICR scenarios plus randomized
// traffic, all compared every cycle against a behavioural model.
module tb_cia_int_ctrl;
  localparam int FLAG_SYNC = 2;

  logic       clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b1;
  logic       cs = 1'b0, wr = 1'b0;
  logic [3:0] rs = '0;
  logic [7:0] data_in = '0, data_out;
  logic [7:0] ta_do = 8'h11, tb_do = 8'h22, tod_do = 8'h33, sdr_do = 8'h44;
  logic       ta_lo, ta_hi, ta_cr, tb_lo, tb_hi, tb_cr, tod_sel, sdr_sel;
  logic       ta_irq = 1'b0, tb_irq = 1'b0, alrm = 1'b0, ser = 1'b0, flag_n = 1'b1;
  logic       irq_n;

  int n_cmp = 0, n_err = 0;

  cia_int_ctrl #(.FLAG_SYNC(FLAG_SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .cs(cs), .wr(wr), .rs(rs),
    .data_in(data_in), .data_out(data_out), .ta_do(ta_do), .tb_do(tb_do),
    .tod_do(tod_do), .sdr_do(sdr_do), .ta_lo(ta_lo), .ta_hi(ta_hi), .ta_cr(ta_cr),
    .tb_lo(tb_lo), .tb_hi(tb_hi), .tb_cr(tb_cr), .tod_sel(tod_sel), .sdr_sel(sdr_sel),
    .ta_irq(ta_irq), .tb_irq(tb_irq), .alrm(alrm), .ser(ser), .flag_n(flag_n),
    .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending flags and mask kept as plain bit arrays; FLAG pin seen through a
  // history of FLAG_SYNC past clock samples.
  bit m_pend[5];
  bit m_mask[5];
  bit m_irq_n = 1'b1;
  bit m_fhist[FLAG_SYNC];
  bit m_fseen = 1'b1;

  initial foreach (m_fhist[i]) m_fhist[i] = 1'b1;

  function automatic bit m_any();
    bit a = 0;
    for (int i = 0; i < 5; i++) a |= m_pend[i] & m_mask[i];
    return a;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) begin m_pend[i] = 0; m_mask[i] = 0; end
      foreach (m_fhist[i]) m_fhist[i] = 1'b1;
      m_fseen = 1'b1;
      m_irq_n = 1'b1;
    end else begin
      bit synced;
      bit ev[5];
      synced = m_fhist[0];
      for (int i = 0; i < FLAG_SYNC - 1; i++) m_fhist[i] = m_fhist[i+1];
      m_fhist[FLAG_SYNC-1] = flag_n;
      if (clk7_en) begin
        ev[0] = ta_irq; ev[1] = tb_irq; ev[2] = alrm; ev[3] = ser;
        ev[4] = m_fseen && !synced;
        m_fseen = synced;
        if (cs && !wr && rs == 4'hD)
          for (int i = 0; i < 5; i++) m_pend[i] = 0;
        for (int i = 0; i < 5; i++) if (ev[i]) m_pend[i] = 1;
        if (cs && wr && rs == 4'hD)
          for (int i = 0; i < 5; i++) if (data_in[i]) m_mask[i] = data_in[7];
        m_irq_n = !m_any();
      end
    end
  end

  function automatic logic [7:0] m_dout();
    logic [7:0] v = 8'h00;
    if (cs && !wr) begin
      if (rs == 4'h4 || rs == 4'h5 || rs == 4'hE) v = ta_do;
      else if (rs == 4'h6 || rs == 4'h7 || rs == 4'hF) v = tb_do;
      else if (rs >= 4'h8 && rs <= 4'hB) v = tod_do;
      else if (rs == 4'hC) v = sdr_do;
      else if (rs == 4'hD) begin
        for (int i = 0; i < 5; i++) v[i] = m_pend[i];
        v[7] = m_any();
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] m_strb();
    logic [7:0] s = 8'h00;
    if (cs) begin
      s[7] = (rs == 4); s[6] = (rs == 5); s[5] = (rs == 14);
      s[4] = (rs == 6); s[3] = (rs == 7); s[2] = (rs == 15);
      s[1] = (rs >= 8 && rs <= 11); s[0] = (rs == 12);
    end
    return s;
  endfunction

  // Inputs change at negedge+1; outputs checked at negedge+3.
  always @(negedge clk) begin
    #3;
    chk("irq_n", irq_n, m_irq_n);
    chk("data_out", data_out, m_dout());
    chk("strobes", {ta_lo, ta_hi, ta_cr, tb_lo, tb_hi, tb_cr, tod_sel, sdr_sel}, m_strb());
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit c, input bit w, input bit [3:0] r, input bit [7:0] d,
                     input bit [3:0] ev, input bit en = 1'b1);
    @(negedge clk); #1;
    cs = c; wr = w; rs = r; data_in = d; clk7_en = en;
    {ser, alrm, tb_irq, ta_irq} = ev;
  endtask

  task automatic idle(input bit en = 1'b1);
    drv(0, 0, 4'h0, 8'h00, 4'h0, en);
  endtask

  task automatic rd_icr(input string nm, input logic [7:0] exp, input bit [3:0] ev = 4'h0,
                        input bit en = 1'b1);
    drv(1, 0, 4'hD, 8'h00, ev, en);
    #2 chk(nm, data_out, exp);
  endtask

  task automatic irq_is(input string nm, input logic exp);
    #2 chk(nm, irq_n, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #3 chk("reset_irq", irq_n, 1'b1);
    #1 reset_n = 1'b1;
    idle();
    rd_icr("reset_icr", 8'h00);

    // unmasked event latches but no irq; read-to-clear
    drv(0, 0, 0, 0, 4'b0001);
    idle(); irq_is("nomask_irq", 1'b1);
    rd_icr("nomask_rd1", 8'h01);
    rd_icr("nomask_rd2", 8'h00);

    // masked tb event
    drv(1, 1, 4'hD, 8'h83, 4'h0);
    drv(0, 0, 0, 0, 4'b0010);
    idle(); irq_is("tb_irq_low", 1'b0);
    rd_icr("tb_rd", 8'h82);
    idle(); irq_is("tb_irq_rel", 1'b1);
    drv(1, 1, 4'hD, 8'h03, 4'h0);

    // mask written after event
    drv(0, 0, 0, 0, 4'b0001);
    idle(); irq_is("late_pre", 1'b1);
    drv(1, 1, 4'hD, 8'h81, 4'h0); irq_is("late_wr_cyc", 1'b1);
    idle(); irq_is("late_low", 1'b0);
    rd_icr("late_rd", 8'h81);
    drv(1, 1, 4'hD, 8'h01, 4'h0);
    idle(); irq_is("late_rel", 1'b1);

    // event coincident with read-clear
    drv(0, 0, 0, 0, 4'b0001);
    rd_icr("coinc_rd1", 8'h01, 4'b1000);
    rd_icr("coinc_rd2", 8'h08);

    // FLAG falling edge, held low
    @(negedge clk); #1 flag_n = 1'b0;
    idle();
    rd_icr("flag_early", 8'h00);
    rd_icr("flag_set", 8'h10);
    for (int i = 0; i < 8; i++) rd_icr("flag_once", 8'h00);
    @(negedge clk); #1 flag_n = 1'b1;
    repeat (3) idle();

    // clock-enable stall
    drv(0, 0, 0, 0, 4'b0001);
    rd_icr("stall_rd1", 8'h01, 4'h0, 1'b0);
    rd_icr("stall_rd2", 8'h01, 4'h0, 1'b0);
    drv(1, 1, 4'hD, 8'h81, 4'h0, 1'b0);
    drv(0, 0, 0, 0, 4'b1000, 1'b0); irq_is("stall_irq", 1'b1);
    rd_icr("stall_rd3", 8'h01);
    rd_icr("stall_rd4", 8'h00);

    // decode
    drv(1, 1, 4'h5, 8'h5A, 4'h0);
    #2 chk("rs5_strb", {ta_lo, ta_hi, ta_cr, tb_lo, tb_hi, tb_cr, tod_sel, sdr_sel}, 8'b0100_0000);
    chk("rs5_dout", data_out, 8'h00);
    drv(1, 0, 4'hE, 8'h00, 4'h0);
    #2 chk("rsE_dout", data_out, 8'h11);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      reset_n = ($urandom_range(0, 299) != 0);
      clk7_en = ($urandom_range(0, 9) < 7);
      cs      = ($urandom_range(0, 3) != 0);
      wr      = $urandom_range(0, 1);
      rs      = ($urandom_range(0, 2) == 0) ? 4'hD : 4'($urandom_range(0, 15));
      data_in = 8'($urandom);
      ta_do = 8'($urandom); tb_do = 8'($urandom); tod_do = 8'($urandom); sdr_do = 8'($urandom);
      ta_irq = ($urandom_range(0, 9) == 0); tb_irq = ($urandom_range(0, 9) == 0);
      alrm   = ($urandom_range(0, 9) == 0); ser    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) flag_n = ~flag_n;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
